// File: rtl/execute_stage.sv
// Y86-64 SEQ execute stage: ALU (valE), condition-code register and branch/cmov condition.
// Latency: valE and Cnd are combinational and CC updates on the clock edge; there is no flow control.
module execute_stage #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       icode,
  input  logic [3:0]       ifun,
  input  logic [WIDTH-1:0] valA,
  input  logic [WIDTH-1:0] valB,
  input  logic [WIDTH-1:0] valC,
  output logic [WIDTH-1:0] valE,
  output logic             Cnd,
  output logic             ZF,
  output logic             SF,
  output logic             OF
);

  localparam logic [3:0] I_RRMOVQ = 4'd2;
  localparam logic [3:0] I_IRMOVQ = 4'd3;
  localparam logic [3:0] I_RMMOVQ = 4'd4;
  localparam logic [3:0] I_MRMOVQ = 4'd5;
  localparam logic [3:0] I_OPQ    = 4'd6;
  localparam logic [3:0] I_JXX    = 4'd7;
  localparam logic [3:0] I_CALL   = 4'd8;
  localparam logic [3:0] I_RET    = 4'd9;
  localparam logic [3:0] I_PUSHQ  = 4'd10;
  localparam logic [3:0] I_POPQ   = 4'd11;

  localparam logic [3:0] F_ADD = 4'd0;
  localparam logic [3:0] F_SUB = 4'd1;
  localparam logic [3:0] F_AND = 4'd2;
  localparam logic [3:0] F_XOR = 4'd3;

  localparam logic [WIDTH-1:0] STACK_STEP = WIDTH'(8);

  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

  localparam cc_t CC_RESET = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

  cc_t        cc;
  cc_t        ccNext;
  logic       opValid;
  logic [WIDTH-1:0] opResult;

  // OPq arithmetic; unused function codes produce zero and leave the CC alone.
  always_comb begin
    opResult = '0;
    opValid  = 1'b1;
    unique case (ifun)
      F_ADD:   opResult = valB + valA;
      F_SUB:   opResult = valB - valA;
      F_AND:   opResult = valB & valA;
      F_XOR:   opResult = valB ^ valA;
      default: opValid  = 1'b0;
    endcase
  end

  always_comb begin
    valE = '0;
    unique case (icode)
      I_RRMOVQ:          valE = valA;
      I_IRMOVQ:          valE = valC;
      I_RMMOVQ, I_MRMOVQ: valE = valB + valC;
      I_OPQ:             valE = opResult;
      I_CALL, I_PUSHQ:   valE = valB - STACK_STEP;
      I_RET, I_POPQ:     valE = valB + STACK_STEP;
      default:           valE = '0;
    endcase
  end

  always_comb begin
    ccNext.zf = (opResult == '0);
    ccNext.sf = opResult[WIDTH-1];
    ccNext.of = 1'b0;
    if (ifun == F_ADD) begin
      ccNext.of = (valA[WIDTH-1] == valB[WIDTH-1]) && (opResult[WIDTH-1] != valA[WIDTH-1]);
    end else if (ifun == F_SUB) begin
      ccNext.of = (valA[WIDTH-1] != valB[WIDTH-1]) && (opResult[WIDTH-1] != valB[WIDTH-1]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cc <= CC_RESET;
    end else if (icode == I_OPQ && opValid) begin
      cc <= ccNext;
    end
  end

  // Condition reads only the registered flags, so an OPq affects branches one cycle later.
  always_comb begin
    Cnd = 1'b0;
    if (icode == I_RRMOVQ || icode == I_JXX) begin
      unique case (ifun)
        4'd0:    Cnd = 1'b1;
        4'd1:    Cnd = (cc.sf ^ cc.of) | cc.zf;
        4'd2:    Cnd = cc.sf ^ cc.of;
        4'd3:    Cnd = cc.zf;
        4'd4:    Cnd = ~cc.zf;
        4'd5:    Cnd = ~(cc.sf ^ cc.of);
        4'd6:    Cnd = ~(cc.sf ^ cc.of) & ~cc.zf;
        default: Cnd = 1'b0;
      endcase
    end
  end

  assign ZF = cc.zf;
  assign SF = cc.sf;
  assign OF = cc.of;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: ALU results, CC update/hold/reset and condition evaluation.
module tb_execute_stage;

  logic        clk;
  logic        reset;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic [63:0] valA;
  logic [63:0] valB;
  logic [63:0] valC;
  logic [63:0] valE;
  logic        Cnd;
  logic        ZF;
  logic        SF;
  logic        OF;

  int total = 0;
  int bad   = 0;

  execute_stage #(.WIDTH(64)) dut (
    .clk   (clk),
    .reset (reset),
    .icode (icode),
    .ifun  (ifun),
    .valA  (valA),
    .valB  (valB),
    .valC  (valC),
    .valE  (valE),
    .Cnd   (Cnd),
    .ZF    (ZF),
    .SF    (SF),
    .OF    (OF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkFlags(input string tag, input logic [2:0] expZSO);
    check(tag, {61'd0, ZF, SF, OF}, {61'd0, expZSO});
  endtask

  task automatic setOp(input logic [3:0] ic, input logic [3:0] fn,
                       input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
    icode = ic;
    ifun  = fn;
    valA  = a;
    valB  = b;
    valC  = c;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // expBits[i] is the expected Cnd for ifun i (0..6); ifun 7 and 15 must give 0.
  task automatic condSweep(input string tag, input logic [3:0] ic, input logic [6:0] expBits);
    logic [6:0] e;
    e = expBits;
    for (int i = 0; i < 7; i++) begin
      setOp(ic, 4'(i), valA, valB, valC);
      check($sformatf("%s_ic%0d_fn%0d", tag, ic, i), {63'd0, Cnd}, {63'd0, e[i]});
    end
    setOp(ic, 4'd7, valA, valB, valC);
    check($sformatf("%s_ic%0d_fn7", tag, ic), {63'd0, Cnd}, 64'd0);
    setOp(ic, 4'd15, valA, valB, valC);
    check($sformatf("%s_ic%0d_fn15", tag, ic), {63'd0, Cnd}, 64'd0);
  endtask

  initial begin
    // Reset wins over an OPq presented in the same cycle (5+3 would clear ZF).
    reset = 1'b1;
    setOp(4'd6, 4'd0, 64'd5, 64'd3, 64'd7);
    tick();
    checkFlags("reset_priority", 3'b100);
    reset = 1'b0;

    // Non-OPq valE paths.
    setOp(4'd2, 4'd0, 64'd5, 64'd3, 64'd7);  check("valE_rrmovq", valE, 64'd5);
    setOp(4'd3, 4'd0, 64'd5, 64'd3, 64'd7);  check("valE_irmovq", valE, 64'd7);
    setOp(4'd4, 4'd0, 64'd5, 64'd3, 64'd7);  check("valE_rmmovq", valE, 64'd10);
    setOp(4'd5, 4'd0, 64'd5, 64'd3, 64'd7);  check("valE_mrmovq", valE, 64'd10);
    setOp(4'd8, 4'd0, 64'd5, 64'd3, 64'd7);  check("valE_call", valE, 64'hFFFF_FFFF_FFFF_FFFB);
    setOp(4'd9, 4'd0, 64'd5, 64'd3, 64'd7);  check("valE_ret", valE, 64'd11);
    setOp(4'd10, 4'd0, 64'd5, 64'd3, 64'd7); check("valE_pushq", valE, 64'hFFFF_FFFF_FFFF_FFFB);
    setOp(4'd11, 4'd0, 64'd5, 64'd3, 64'd7); check("valE_popq", valE, 64'd11);
    setOp(4'd0, 4'd0, 64'd5, 64'd3, 64'd7);  check("valE_halt", valE, 64'd0);
    setOp(4'd7, 4'd0, 64'd5, 64'd3, 64'd7);  check("valE_jxx", valE, 64'd0);
    setOp(4'd12, 4'd0, 64'd5, 64'd3, 64'd7); check("valE_ic12", valE, 64'd0);
    setOp(4'd15, 4'd0, 64'd5, 64'd3, 64'd7); check("valE_ic15", valE, 64'd0);

    // OPq valE.
    setOp(4'd6, 4'd0, 64'd5, 64'd3, 64'd7); check("op_add", valE, 64'd8);
    setOp(4'd6, 4'd2, 64'd5, 64'd3, 64'd7); check("op_and", valE, 64'd1);
    setOp(4'd6, 4'd3, 64'd5, 64'd3, 64'd7); check("op_xor", valE, 64'd6);
    setOp(4'd6, 4'd4, 64'd5, 64'd3, 64'd7); check("op_fn4", valE, 64'd0);
    setOp(4'd6, 4'd1, 64'd5, 64'd3, 64'd7); check("op_sub", valE, 64'hFFFF_FFFF_FFFF_FFFE);

    // Negative result: SF=1.
    tick();
    checkFlags("cc_neg", 3'b010);
    condSweep("neg", 4'd7, 7'b0010111);
    condSweep("neg", 4'd2, 7'b0010111);

    // Unused OPq function code leaves CC untouched.
    setOp(4'd6, 4'd9, 64'd5, 64'd5, 64'd7);
    tick();
    checkFlags("cc_fn9_hold", 3'b010);

    // Zero result: ZF=1.
    setOp(4'd6, 4'd1, 64'd5, 64'd5, 64'd7);
    check("op_sub_zero", valE, 64'd0);
    tick();
    checkFlags("cc_zero", 3'b100);
    condSweep("zero", 4'd7, 7'b0101011);
    condSweep("zero", 4'd2, 7'b0101011);

    // Positive result.
    setOp(4'd6, 4'd0, 64'd5, 64'd3, 64'd7);
    tick();
    checkFlags("cc_pos", 3'b000);
    condSweep("pos", 4'd7, 7'b1110001);

    // Signed add overflow.
    setOp(4'd6, 4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0);
    check("op_add_ovf", valE, 64'hFFFF_FFFF_FFFF_FFFE);
    tick();
    checkFlags("cc_add_ovf", 3'b011);
    condSweep("addovf", 4'd7, 7'b1110001);

    // Signed sub overflow: 0x8000..0 - 1.
    setOp(4'd6, 4'd1, 64'd1, 64'h8000_0000_0000_0000, 64'd0);
    check("op_sub_ovf", valE, 64'h7FFF_FFFF_FFFF_FFFF);
    tick();
    checkFlags("cc_sub_ovf", 3'b001);
    condSweep("subovf", 4'd7, 7'b0010111);

    // Logical ops clear OF.
    setOp(4'd6, 4'd3, 64'd5, 64'd3, 64'd0);
    tick();
    checkFlags("cc_xor_clear_of", 3'b000);

    // Drive to the negative state, then hold across several non-OPq edges.
    setOp(4'd6, 4'd1, 64'd5, 64'd3, 64'd7);
    tick();
    checkFlags("cc_neg2", 3'b010);
    setOp(4'd2, 4'd0, 64'd0, 64'd0, 64'd0); tick();
    setOp(4'd3, 4'd0, 64'd0, 64'd0, 64'd0); tick();
    setOp(4'd7, 4'd0, 64'd0, 64'd0, 64'd0); tick();
    setOp(4'd4, 4'd0, 64'd0, 64'd0, 64'd0); tick();
    checkFlags("cc_hold", 3'b010);

    // Cnd is zero for icodes other than 2 and 7.
    setOp(4'd4, 4'd0, 64'd0, 64'd0, 64'd0); check("cnd_ic4_fn0", {63'd0, Cnd}, 64'd0);
    setOp(4'd4, 4'd2, 64'd0, 64'd0, 64'd0); check("cnd_ic4_fn2", {63'd0, Cnd}, 64'd0);
    setOp(4'd6, 4'd0, 64'd0, 64'd0, 64'd0); check("cnd_ic6_fn0", {63'd0, Cnd}, 64'd0);

    // Reset again from a non-reset state.
    reset = 1'b1;
    setOp(4'd6, 4'd1, 64'd5, 64'd3, 64'd0);
    tick();
    checkFlags("reset_again", 3'b100);
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Execute (E) stage of the single-cycle (SEQ) Y86-64 processor.
- Combinational ALU produces valE from valA/valB/valC per icode/ifun.
- Holds the architectural condition-code register (ZF, SF, OF), updated only by OPq.
- Evaluates the branch/cmov condition Cnd from the registered condition codes; sits between decode and memory stages.

Parameters:
- WIDTH, 64, datapath width of valA/valB/valC/valE.

Ports:
- clk  input  1  system clock; CC register updates on rising edge.
- reset  input  1  synchronous, active-high reset of the CC register.
- icode  input  4  instruction code.
- ifun  input  4  function code.
- valA  input  WIDTH  operand A from decode.
- valB  input  WIDTH  operand B from decode.
- valC  input  WIDTH  immediate/displacement from fetch.
- valE  output  WIDTH  ALU result, combinational.
- Cnd  output  1  condition result, combinational from registered CC.
- ZF  output  1  registered zero flag.
- SF  output  1  registered sign flag.
- OF  output  1  registered overflow flag.

Behaviour:
- valE by icode (combinational, two's-complement, wraps mod 2^64, no carry out):
  - 2 rrmovq/cmovXX: valA.
  - 3 irmovq: valC.
  - 4 rmmovq, 5 mrmovq: valB + valC.
  - 6 OPq: ifun 0 valB+valA, 1 valB-valA, 2 valB&valA, 3 valB^valA; ifun>3 -> 0.
  - 8 call, 10 pushq: valB - 8.
  - 9 ret, 11 popq: valB + 8.
  - 0, 1, 7, 12-15: 0.
- CC register (ZF, SF, OF):
  - Synchronous reset (reset=1 at rising edge) -> ZF=1, SF=0, OF=0. Reset has priority over any update in the same cycle.
  - At rising edge with reset=0, icode=6 and ifun<=3: ZF = (valE==0), SF = valE[63].
  - OF for add: valA[63]==valB[63] && valE[63]!=valA[63].
  - OF for sub: valA[63]!=valB[63] && valE[63]!=valB[63].
  - OF for and/xor: 0.
  - Otherwise CC holds.
- Cnd (combinational from current registered flags, never from the same-cycle OPq result):
  - Applies only for icode 2 or 7; all other icodes -> Cnd=0.
  - ifun 0 always: 1.
  - ifun 1 le: (SF^OF)|ZF.
  - ifun 2 l: SF^OF.
  - ifun 3 e: ZF.
  - ifun 4 ne: ~ZF.
  - ifun 5 ge: ~(SF^OF).
  - ifun 6 g: ~(SF^OF)&~ZF.
  - ifun 7-15: 0.
- Latency: valE and Cnd zero-cycle combinational. CC effect visible on Cnd in the cycle after the OPq edge.
- Undefined inputs are not sanitised; no X propagation into CC beyond input X.

Test Plan:
- valA=5, valB=3, valC=7, ifun=0: icode 2->valE=5; 3->7; 4->10; 5->10; 8->-5 (0xFFFF_FFFF_FFFF_FFFB); 9->11; 10->-5; 11->11.
- icode=6, valA=5, valB=3: ifun0->8, 1->-2 (after edge SF=1, ZF=0, OF=0), 2->1, 3->6. ifun=1 with valB=5 -> valE=0, after edge ZF=1, SF=0.
- Overflow: icode=6, ifun=0, valA=valB=0x7FFF_FFFF_FFFF_FFFF -> valE=0xFFFF_FFFF_FFFF_FFFE, after edge OF=1, SF=1.
- Overflow, sub: ifun=1, valB=0x8000_0000_0000_0000, valA=1 -> OF=1, SF=0.
- Conditions: after OPq yielding -2 (SF=1, OF=0, ZF=0), icode 7 ifun 0..6 -> Cnd 1,1,1,0,1,0,0. After result 0 (ZF=1) -> 1,1,0,1,0,1,0. After positive result -> 1,0,0,0,1,1,1. icode 2 gives identical Cnd.
- Reset/hold: assert reset with icode=6 in the same cycle -> flags ZF=1, SF=0, OF=0. Non-OPq icodes (2,3,7) for several edges -> flags unchanged. icode 4 -> Cnd=0 regardless of flags.
